// File: rtl/imm_pkg.sv
// Shared definitions for the decode-stage immediate generator: mode encoding,
// instruction field positions and the field extension helper.
package imm_pkg;

  // Immediate mode encoding carried on imm_sel; codes 6 and 7 are illegal.
  typedef enum logic [2:0] {
    DADDR9 = 3'd0,
    IMM12  = 3'd1,
    COND19 = 3'd2,
    BR26   = 3'd3,
    MOVZ16 = 3'd4,
    ZERO   = 3'd5
  } imm_sel_t;

  // Field positions inside the 32-bit instruction word.
  localparam int unsigned DADDR9_LSB  = 32'd12;
  localparam int unsigned DADDR9_MSB  = 32'd20;
  localparam int unsigned IMM12_LSB   = 32'd10;
  localparam int unsigned IMM12_MSB   = 32'd21;
  localparam int unsigned COND19_LSB  = 32'd5;
  localparam int unsigned COND19_MSB  = 32'd23;
  localparam int unsigned BR26_LSB    = 32'd0;
  localparam int unsigned BR26_MSB    = 32'd25;
  localparam int unsigned MOVZ16_LSB  = 32'd5;
  localparam int unsigned MOVZ16_MSB  = 32'd20;
  localparam int unsigned MOVZ_HW_LSB = 32'd21;
  localparam int unsigned MOVZ_HW_MSB = 32'd22;

  // Word-to-byte offset shift applied to branch displacements.
  localparam int unsigned BR_SHIFT = 32'd2;

  // Pull raw[msb:lsb] down to bit 0 and extend it to 64 bits. The sign bit is
  // found by masking with the top bit of the field mask so no variable bit
  // index is needed.
  function automatic logic [63:0] extend_field(
    input logic [31:0]  raw,
    input int unsigned  lsb,
    input int unsigned  msb,
    input logic         zext
  );
    logic [63:0] mask;
    logic [63:0] val;
    logic [63:0] top;
    logic        sign;
    mask = (64'd1 << (msb - lsb + 32'd1)) - 64'd1;
    val  = ({32'd0, raw} >> lsb) & mask;
    top  = mask ^ (mask >> 1);
    sign = |(val & top);
    if (zext || !sign) begin
      extend_field = val;
    end else begin
      extend_field = val | ~mask;
    end
  endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction: selects the field for the requested
// mode, extends it, applies the branch shift or MOVZ placement, and flags
// illegal modes and out-of-range MOVZ placements.
module imm_extract
  import imm_pkg::*;
#(
  parameter int unsigned WIDTH        = 64,
  parameter int unsigned SHIFT_BRANCH = 1,
  parameter int unsigned HW_CHECK     = 1
) (
  input  logic [31:0]      instr_i,
  input  logic [2:0]       imm_sel_i,
  input  logic             zero_ext_i,
  output logic [WIDTH-1:0] imm_o,
  output logic             err_o
);

  localparam logic [6:0] WIDTH_L = 7'(WIDTH);

  logic [63:0] daddr_s;
  logic [63:0] imm12_s;
  logic [63:0] cond_s;
  logic [63:0] br_s;
  logic [63:0] movz_s;
  logic [1:0]  hw_s;
  logic [6:0]  movz_top_s;
  logic        movz_ovf_s;
  logic [63:0] wide_s;

  // Per-mode candidates, all computed at 64 bits and truncated at the end.
  always_comb begin
    daddr_s    = extend_field(instr_i, DADDR9_LSB, DADDR9_MSB, zero_ext_i);
    imm12_s    = extend_field(instr_i, IMM12_LSB, IMM12_MSB, zero_ext_i);
    cond_s     = extend_field(instr_i, COND19_LSB, COND19_MSB, zero_ext_i);
    br_s       = extend_field(instr_i, BR26_LSB, BR26_MSB, zero_ext_i);
    hw_s       = instr_i[MOVZ_HW_MSB:MOVZ_HW_LSB];
    // MOVZ is always zero-filled; the chunk lands at bit 16*hw.
    movz_s     = {48'd0, instr_i[MOVZ16_MSB:MOVZ16_LSB]} << {hw_s, 4'b0000};
    movz_top_s = {1'b0, hw_s, 4'b0000} + 7'd16;
    movz_ovf_s = (HW_CHECK != 32'd0) && (movz_top_s > WIDTH_L);
  end

  // Mode select; branch displacements are shifted after extension so the
  // sign reaches the top bit before truncation to WIDTH.
  always_comb begin
    wide_s = 64'd0;
    err_o  = 1'b0;
    case (imm_sel_i)
      DADDR9: begin
        wide_s = daddr_s;
        err_o  = 1'b0;
      end
      IMM12: begin
        wide_s = imm12_s;
        err_o  = 1'b0;
      end
      COND19: begin
        wide_s = (SHIFT_BRANCH != 32'd0) ? (cond_s << BR_SHIFT) : cond_s;
        err_o  = 1'b0;
      end
      BR26: begin
        wide_s = (SHIFT_BRANCH != 32'd0) ? (br_s << BR_SHIFT) : br_s;
        err_o  = 1'b0;
      end
      MOVZ16: begin
        if (movz_ovf_s) begin
          wide_s = 64'd0;
          err_o  = 1'b1;
        end else begin
          wide_s = movz_s;
          err_o  = 1'b0;
        end
      end
      ZERO: begin
        wide_s = 64'd0;
        err_o  = 1'b0;
      end
      default: begin
        wide_s = 64'd0;
        err_o  = 1'b1;
      end
    endcase
  end

  assign imm_o = wide_s[WIDTH-1:0];

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate generator stage: one selected, extended immediate per
// accepted instruction, held in a valid/ready pipeline register with flush.
// WIDTH is meant to lie in 32..64.
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int unsigned WIDTH        = 64,
  parameter int unsigned SHIFT_BRANCH = 1,
  parameter int unsigned HW_CHECK     = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       imm_sel,
  input  logic             zero_ext,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] imm,
  output logic [2:0]       imm_sel_q,
  output logic             err
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] imm_q, imm_d;
  logic [2:0]       sel_q, sel_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] ext_imm_s;
  logic             ext_err_s;
  logic             accept_s;

  imm_extract #(
    .WIDTH       (WIDTH),
    .SHIFT_BRANCH(SHIFT_BRANCH),
    .HW_CHECK    (HW_CHECK)
  ) u_extract (
    .instr_i   (instr),
    .imm_sel_i (imm_sel),
    .zero_ext_i(zero_ext),
    .imm_o     (ext_imm_s),
    .err_o     (ext_err_s)
  );

  // Ready whenever the register is empty or being drained; flush does not
  // gate ready, it only blocks the capture.
  always_comb begin
    in_ready = !valid_q || out_ready;
    accept_s = in_valid && in_ready && !flush;
  end

  // Next-state: flush drops everything, capture loads a new result, otherwise
  // the result is held until the consumer takes it. Data only moves on a
  // capture so it stays stable while held and after a drain or flush.
  always_comb begin
    valid_d = valid_q;
    imm_d   = imm_q;
    sel_d   = sel_q;
    err_d   = err_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept_s) begin
      valid_d = 1'b1;
      imm_d   = ext_imm_s;
      sel_d   = imm_sel;
      err_d   = ext_err_s;
    end else begin
      valid_d = valid_q && !out_ready;
    end
  end

  // Pipeline register; reset overrides flush and capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      imm_q   <= '0;
      sel_q   <= 3'd0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      imm_q   <= imm_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = valid_q;
  assign imm       = imm_q;
  assign imm_sel_q = sel_q;
  assign err       = err_q && valid_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Scoreboard bench for imm_gen_stage. Two instances share the stimulus: the
// default 64-bit build and a WIDTH=32, SHIFT_BRANCH=0 build, each with its own
// expected-result queue drained by a negedge monitor.
module tb_imm_gen_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, zero_ext, out_ready;
  logic [31:0] instr;
  logic [2:0]  imm_sel;

  logic        in_ready64, out_valid64, err64;
  logic [63:0] imm64;
  logic [2:0]  sel_q64;
  logic        in_ready32, out_valid32, err32;
  logic [31:0] imm32;
  logic [2:0]  sel_q32;

  typedef struct packed {
    logic [63:0] imm;
    logic        err;
    logic [2:0]  sel;
  } exp_t;

  typedef struct packed {
    logic [31:0] ins;
    logic [2:0]  sel;
    logic        zx;
    logic [63:0] e64;
    logic        r64;
    logic [31:0] e32;
    logic        r32;
  } vec_t;

  localparam int NVEC = 18;
  vec_t tbl [NVEC];
  exp_t q64 [$];
  exp_t q32 [$];
  int   n_vec = 0;
  int   n_fail = 0;
  int   hs64 = 0;

  always #5 clk = ~clk;

  imm_gen_stage u_dut64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .instr(instr), .imm_sel(imm_sel), .zero_ext(zero_ext), .out_valid(out_valid64),
    .out_ready(out_ready), .imm(imm64), .imm_sel_q(sel_q64), .err(err64)
  );

  imm_gen_stage #(.WIDTH(32), .SHIFT_BRANCH(0), .HW_CHECK(1)) u_dut32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .instr(instr), .imm_sel(imm_sel), .zero_ext(zero_ext), .out_valid(out_valid32),
    .out_ready(out_ready), .imm(imm32), .imm_sel_q(sel_q32), .err(err32)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every presented result with the queue head, pop on handshake.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid64) begin
        if (q64.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL unexpected64: got %h, expected no output at %0t", imm64, $time);
        end else begin
          check("imm64", imm64, q64[0].imm);
          check("err64", {63'd0, err64}, {63'd0, q64[0].err});
          check("sel64", {61'd0, sel_q64}, {61'd0, q64[0].sel});
          if (out_ready) void'(q64.pop_front());
        end
        if (out_ready) hs64++;
      end
      if (out_valid32) begin
        if (q32.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL unexpected32: got %h, expected no output at %0t", imm32, $time);
        end else begin
          check("imm32", {32'd0, imm32}, {32'd0, q32[0].imm[31:0]});
          check("err32", {63'd0, err32}, {63'd0, q32[0].err});
          check("sel32", {61'd0, sel_q32}, {61'd0, q32[0].sel});
          if (out_ready) void'(q32.pop_front());
        end
      end
    end
  end

  // Present one instruction until accepted; called at posedge+1, returns at posedge+1.
  task automatic send(input vec_t v, output int cycles);
    logic acc;
    exp_t e;
    in_valid = 1'b1; instr = v.ins; imm_sel = v.sel; zero_ext = v.zx;
    cycles = 0; acc = 1'b0;
    while (!acc && cycles < 20) begin
      #1;
      acc = in_ready64 && !flush;
      @(posedge clk); #1;
      cycles++;
    end
    in_valid = 1'b0;
    if (acc) begin
      e.imm = v.e64; e.err = v.r64; e.sel = v.sel; q64.push_back(e);
      e.imm = {32'd0, v.e32}; e.err = v.r32; e.sel = v.sel; q32.push_back(e);
    end else begin
      n_vec++; n_fail++;
      $display("FAIL send_timeout: got no acceptance, expected acceptance within 20 cycles");
    end
  endtask

  initial begin
    int c;
    int total;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; instr = 32'd0;
    imm_sel = 3'd0; zero_ext = 1'b0; out_ready = 1'b0;

    //              instr          sel   zx    exp64                   err   exp32         err
    tbl[0]  = '{32'h001FF000, 3'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 32'hFFFFFFFF, 1'b0};
    tbl[1]  = '{32'h001FF000, 3'd0, 1'b1, 64'h0000_0000_0000_01FF, 1'b0, 32'h000001FF, 1'b0};
    tbl[2]  = '{32'h000FF000, 3'd0, 1'b0, 64'h0000_0000_0000_00FF, 1'b0, 32'h000000FF, 1'b0};
    tbl[3]  = '{32'h00200000, 3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_F800, 1'b0, 32'hFFFFF800, 1'b0};
    tbl[4]  = '{32'h00200000, 3'd1, 1'b1, 64'h0000_0000_0000_0800, 1'b0, 32'h00000800, 1'b0};
    tbl[5]  = '{32'h03FFFFFF, 3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 32'hFFFFFFFF, 1'b0};
    tbl[6]  = '{32'h03FFFFFF, 3'd3, 1'b1, 64'h0000_0000_0FFF_FFFC, 1'b0, 32'h03FFFFFF, 1'b0};
    tbl[7]  = '{32'h00000020, 3'd2, 1'b0, 64'h0000_0000_0000_0004, 1'b0, 32'h00000001, 1'b0};
    tbl[8]  = '{32'h00800000, 3'd2, 1'b0, 64'hFFFF_FFFF_FFF0_0000, 1'b0, 32'hFFFC0000, 1'b0};
    tbl[9]  = '{32'h00800000, 3'd2, 1'b1, 64'h0000_0000_0010_0000, 1'b0, 32'h00040000, 1'b0};
    tbl[10] = '{32'h005579A0, 3'd4, 1'b0, 64'h0000_ABCD_0000_0000, 1'b0, 32'h00000000, 1'b1};
    tbl[11] = '{32'h00024680, 3'd4, 1'b0, 64'h0000_0000_0000_1234, 1'b0, 32'h00001234, 1'b0};
    tbl[12] = '{32'h00100000, 3'd4, 1'b0, 64'h0000_0000_0000_8000, 1'b0, 32'h00008000, 1'b0};
    tbl[13] = '{32'h007FFFE0, 3'd4, 1'b1, 64'hFFFF_0000_0000_0000, 1'b0, 32'h00000000, 1'b1};
    tbl[14] = '{32'h0037DDE0, 3'd4, 1'b0, 64'h0000_0000_BEEF_0000, 1'b0, 32'hBEEF0000, 1'b0};
    tbl[15] = '{32'hFFFFFFFF, 3'd5, 1'b0, 64'h0000_0000_0000_0000, 1'b0, 32'h00000000, 1'b0};
    tbl[16] = '{32'h12345678, 3'd6, 1'b0, 64'h0000_0000_0000_0000, 1'b1, 32'h00000000, 1'b1};
    tbl[17] = '{32'hFFFFFFFF, 3'd7, 1'b1, 64'h0000_0000_0000_0000, 1'b1, 32'h00000000, 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_out_valid", {63'd0, out_valid64}, 64'd0);
    check("rst_imm", imm64, 64'd0);
    check("rst_err", {63'd0, err64}, 64'd0);
    check("rst_sel", {61'd0, sel_q64}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready64}, 64'd1);
    check("rst_imm32", {32'd0, imm32}, 64'd0);

    // Full-throughput stream of every vector
    out_ready = 1'b1;
    total = 0;
    for (int i = 0; i < NVEC; i++) begin
      send(tbl[i], c);
      total += c;
    end
    check("stream_cycles", 64'(total), 64'(NVEC));
    repeat (3) @(posedge clk);
    #1 check("stream_results", 64'(hs64), 64'(NVEC));

    // Backpressure: A held for 3 cycles while B waits, then B follows
    out_ready = 1'b0;
    send(tbl[10], c);
    in_valid = 1'b1; instr = tbl[5].ins; imm_sel = tbl[5].sel; zero_ext = tbl[5].zx;
    repeat (3) begin
      #1;
      check("hold_in_ready", {63'd0, in_ready64}, 64'd0);
      check("hold_imm", imm64, tbl[10].e64);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(tbl[5], c);
    check("bp_accept_cycles", 64'(c), 64'd1);
    repeat (3) @(posedge clk);
    #1;

    // Flush alongside a valid input on an empty stage
    in_valid = 1'b1; instr = tbl[0].ins; imm_sel = tbl[0].sel; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_in_valid", {63'd0, out_valid64}, 64'd0);
    check("flush_in_valid32", {63'd0, out_valid32}, 64'd0);

    // Flush while a result is held: both held and incoming are dropped
    out_ready = 1'b0;
    send(tbl[3], c);
    in_valid = 1'b1; instr = tbl[0].ins; imm_sel = tbl[0].sel; zero_ext = tbl[0].zx;
    flush = 1'b1;
    #1 check("flush_in_ready", {63'd0, in_ready64}, 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    if (q64.size() > 0) void'(q64.pop_front());
    if (q32.size() > 0) void'(q32.pop_front());
    check("flush_held_valid", {63'd0, out_valid64}, 64'd0);
    check("flush_imm_kept", imm64, tbl[3].e64);

    // Reset while holding a result
    send(tbl[13], c);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    q64.delete();
    q32.delete();
    check("rsthold_valid", {63'd0, out_valid64}, 64'd0);
    check("rsthold_imm", imm64, 64'd0);
    check("rsthold_err", {63'd0, err64}, 64'd0);
    check("rsthold_sel", {61'd0, sel_q64}, 64'd0);
    check("rsthold_in_ready", {63'd0, in_ready64}, 64'd1);
    check("rsthold_imm32", {32'd0, imm32}, 64'd0);

    // Recovery after reset, then everything issued must have been seen
    out_ready = 1'b1;
    send(tbl[16], c);
    repeat (3) @(posedge clk);
    #1;
    check("q64_empty", 64'(q64.size()), 64'd0);
    check("q32_empty", 64'(q32.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
Parametrised, registered immediate generator for the decode stage of the 64-bit pipeline. It extracts the immediate field selected by a mode input from a 32-bit instruction. It then sign- or zero-extends the field to WIDTH, applies the branch word-offset shift, and holds the result in a valid/ready pipeline register with flush. It replaces the purely combinational four-output extender with one selected, registered result per instruction.

Parameters:
WIDTH, 64, output immediate width; legal 32..64
SHIFT_BRANCH, 1, 1 = COND19/BR26 results are shifted left 2 (byte offset); 0 = raw word offset
HW_CHECK, 1, 1 = raise err when a MOVZ shift places bits above WIDTH-1

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
flush  in  1  synchronous pipeline flush
in_valid  in  1  instruction present
in_ready  out  1  stage can accept this cycle
instr  in  32  instruction word
imm_sel  in  3  0 DADDR9, 1 IMM12, 2 COND19, 3 BR26, 4 MOVZ16, 5 ZERO, 6-7 illegal
zero_ext  in  1  1 = zero-extend instead of sign-extend (modes 0-3)
out_valid  out  1  imm/err valid
out_ready  in  1  downstream accepts
imm  out  WIDTH  extended immediate
imm_sel_q  out  3  registered imm_sel
err  out  1  illegal mode or MOVZ overflow, qualified by out_valid

Behaviour:
- Field extraction:
  - DADDR9 = instr[20:12], sign bit instr[20].
  - IMM12 = instr[21:10], sign bit instr[21].
  - COND19 = instr[23:5], sign bit instr[23].
  - BR26 = instr[25:0], sign bit instr[25].
- Extension: replicate the sign bit from the field MSB+1 up to WIDTH-1. If zero_ext=1, fill with 0.
- Branch shift: when SHIFT_BRANCH=1, COND19/BR26 are extended first, then shifted left 2. The two LSBs are 0 and the result is truncated to WIDTH.
- MOVZ16:
  - Field is instr[20:5] placed at bit 16*hw, where hw = instr[22:21]. Always zero-filled; zero_ext is ignored.
  - If 16*hw+16 > WIDTH and HW_CHECK=1: imm = 0, err = 1. If HW_CHECK=0, bits above WIDTH-1 are truncated and err = 0.
- ZERO: imm = 0, err = 0. Illegal modes 6-7: imm = 0, err = 1.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Capture occurs on the clock edge with in_valid && in_ready && !flush. Next cycle: out_valid = 1 and imm/imm_sel_q/err are updated.
  - Latency is exactly 1 cycle from accepted input to out_valid.
- Hold: while out_valid=1 and out_ready=0, imm, imm_sel_q and err are stable and in_ready=0.
- Drain: when out_valid && out_ready && !in_valid, out_valid goes to 0 next cycle and imm keeps its last value.
- Full throughput: in_valid and out_ready held high give one result per cycle.
- Flush: takes priority over capture. Next cycle out_valid = 0 and the held and incoming instructions are both dropped; imm is unchanged. in_ready is unaffected by flush.
- Reset: takes priority over flush and capture. Next cycle out_valid = 0, imm = 0, imm_sel_q = 0, err = 0. Reset asserted mid-hold discards the held result.
- No X propagation: with in_valid=0, instr and imm_sel are don't-care and are not captured.

Decomposition:
- Shared package imm_pkg:
  - imm_sel_t enum: DADDR9=0, IMM12=1, COND19=2, BR26=3, MOVZ16=4, ZERO=5.
  - Field LSB/MSB localparams for each mode.
  - BR_SHIFT=2.
- Sub-module imm_extract: combinational, parametrised by WIDTH, SHIFT_BRANCH and HW_CHECK. It produces the next imm and err from instr, imm_sel and zero_ext.
- imm_gen_stage holds only the pipeline register and handshake.

Test Plan:
- DADDR9: instr=32'h001FF000, sel=0, zero_ext=0 -> next cycle out_valid=1, imm=64'hFFFF_FFFF_FFFF_FFFF. Repeat with zero_ext=1 -> imm=64'h1FF.
- IMM12: instr=32'h00200000, sel=1 -> imm=64'hFFFF_FFFF_FFFF_F800. With zero_ext=1 -> imm=64'h800.
- Branch shift: instr=32'h03FFFFFF, sel=3 -> imm=64'hFFFF_FFFF_FFFF_FFFC. instr=32'h00000020, sel=2 -> imm=64'h4. With SHIFT_BRANCH=0 the same inputs give 64'hFFFF_FFFF_FFFF_FFFF and 64'h1.
- MOVZ and illegal:
  - instr=32'h005579A0, sel=4 -> imm=64'h0000_ABCD_0000_0000, err=0.
  - WIDTH=32 with hw=2 -> imm=0, err=1.
  - sel=6 -> imm=0, err=1.
- Backpressure: accept instr A, hold out_ready=0 for 3 cycles with B on the input -> imm stays A, in_ready=0. Raise out_ready -> B appears the next cycle with no loss or duplication. Streaming 8 instructions with both sides high gives 8 results in 8 consecutive cycles.
- Flush and reset:
  - flush in the same cycle as a valid input -> out_valid=0 next cycle.
  - reset while holding a result -> out_valid=0, imm=0, err=0 next cycle; in_ready=1 afterwards.
